// File: rtl/bist_sram_arbiter_if.sv
// Bundle for the BIST/SRAM arbiter: functional request port, BIST control/status,
// engine request port and the shared SRAM port.
interface bist_sram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4
);
  logic                  bist_start;
  logic                  bist_abort;
  logic [1:0]            pattern_sel;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [MASK_WIDTH-1:0] req_wmask;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic                  eng_rst;
  logic                  eng_en;
  logic [1:0]            eng_pattern_sel;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_data;
  logic [MASK_WIDTH-1:0] eng_wmask;
  logic                  eng_we;
  logic                  eng_re;
  logic                  eng_done;
  logic                  eng_fail;

  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [MASK_WIDTH-1:0] sram_wmask;
  logic                  sram_we;
  logic                  sram_re;
  logic [DATA_WIDTH-1:0] sram_dout;

  logic                  bist_busy;
  logic                  bist_done;
  logic                  bist_fail;
  logic                  bist_timeout;

  // Arbiter side.
  modport slave (
    input  bist_start, bist_abort, pattern_sel,
    input  req_valid, req_we, req_addr, req_data, req_wmask,
    output req_ready, rsp_valid, rsp_data,
    output eng_rst, eng_en, eng_pattern_sel,
    input  eng_addr, eng_data, eng_wmask, eng_we, eng_re, eng_done, eng_fail,
    output sram_addr, sram_din, sram_wmask, sram_we, sram_re,
    input  sram_dout,
    output bist_busy, bist_done, bist_fail, bist_timeout
  );

  // Requestor / engine / SRAM side.
  modport master (
    output bist_start, bist_abort, pattern_sel,
    output req_valid, req_we, req_addr, req_data, req_wmask,
    input  req_ready, rsp_valid, rsp_data,
    input  eng_rst, eng_en, eng_pattern_sel,
    output eng_addr, eng_data, eng_wmask, eng_we, eng_re, eng_done, eng_fail,
    input  sram_addr, sram_din, sram_wmask, sram_we, sram_re,
    output sram_dout,
    input  bist_busy, bist_done, bist_fail, bist_timeout
  );
endinterface

// File: rtl/bist_sram_arbiter.sv
// Shares one SRAM port between functional traffic and a BIST engine; sequences engine
// reset/run, enforces a watchdog and keeps sticky run status.
module bist_sram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MASK_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input logic                clk,
  input logic                rst,
  bist_sram_arbiter_if.slave bus
);

  localparam int unsigned WdWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBistRst, StBistRun} state_e;

  state_e state_q, state_d;

  logic [WdWidth-1:0] wd_q;
  logic [1:0]         pat_q;
  logic               rd_pend_q;
  logic               done_q, fail_q, timeout_q;

  logic start_acc, run_done, run_timeout, run_abort;
  logic rd_acc;

  logic                  ready_c, sram_we_c, sram_re_c, eng_rst_c, eng_en_c;
  logic [ADDR_WIDTH-1:0] sram_addr_c;
  logic [DATA_WIDTH-1:0] sram_din_c;
  logic [MASK_WIDTH-1:0] sram_wmask_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; engine completion beats abort and watchdog expiry.
  always_comb begin
    start_acc   = (state_q == StIdle) && bus.bist_start;
    run_done    = (state_q == StBistRun) && bus.eng_done;
    run_timeout = (state_q == StBistRun) && !bus.eng_done && (wd_q == WdLast);
    run_abort   = (state_q == StBistRun) && !bus.eng_done && !run_timeout && bus.bist_abort;
    state_d     = state_q;
    unique case (state_q)
      StIdle:    if (start_acc) state_d = StBistRst;
      StBistRst: state_d = StBistRun;
      StBistRun: if (run_done || run_timeout || run_abort) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    ready_c      = 1'b0;
    eng_rst_c    = rst;
    eng_en_c     = 1'b0;
    sram_addr_c  = bus.req_addr;
    sram_din_c   = bus.req_data;
    sram_wmask_c = bus.req_wmask;
    sram_we_c    = 1'b0;
    sram_re_c    = 1'b0;
    rd_acc       = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_c   = !bus.bist_start;
        sram_we_c = !rst && bus.req_valid && ready_c && bus.req_we;
        sram_re_c = !rst && bus.req_valid && ready_c && !bus.req_we;
        rd_acc    = sram_re_c;
      end
      StBistRst: eng_rst_c = 1'b1;
      StBistRun: begin
        eng_en_c     = !rst;
        sram_addr_c  = bus.eng_addr;
        sram_din_c   = bus.eng_data;
        sram_wmask_c = bus.eng_wmask;
        sram_we_c    = !rst && bus.eng_we;
        sram_re_c    = !rst && bus.eng_re;
      end
      default: ;
    endcase
  end

  // Status, watchdog, pattern latch and read-response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      pat_q     <= 2'b00;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_acc;
      if (start_acc) begin
        wd_q      <= '0;
        pat_q     <= bus.pattern_sel;
        done_q    <= 1'b0;
        fail_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (state_q == StBistRun) wd_q <= wd_q + WdWidth'(1);
      if (run_done) begin
        done_q <= 1'b1;
        fail_q <= bus.eng_fail;
      end
      if (run_timeout) begin
        done_q    <= 1'b1;
        fail_q    <= 1'b1;
        timeout_q <= 1'b1;
      end
      if (run_abort) begin
        done_q <= 1'b1;
        fail_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready       = ready_c;
  assign bus.rsp_valid       = rd_pend_q;
  assign bus.rsp_data        = bus.sram_dout;
  assign bus.eng_rst         = eng_rst_c;
  assign bus.eng_en          = eng_en_c;
  assign bus.eng_pattern_sel = pat_q;
  assign bus.sram_addr       = sram_addr_c;
  assign bus.sram_din        = sram_din_c;
  assign bus.sram_wmask      = sram_wmask_c;
  assign bus.sram_we         = sram_we_c;
  assign bus.sram_re         = sram_re_c;
  assign bus.bist_busy       = (state_q != StIdle);
  assign bus.bist_done       = done_q;
  assign bus.bist_fail       = fail_q;
  assign bus.bist_timeout    = timeout_q;

endmodule

// File: tb/tb_bist_sram_arbiter.sv
// Directed bench for bist_sram_arbiter: a byte-masked SRAM model with one-cycle read
// latency, engine inputs driven by hand, outputs checked half a cycle after each edge.
module tb_bist_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] mem [256];

  bist_sram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .MASK_WIDTH(4)) bus ();

  bist_sram_arbiter #(
    .ADDR_WIDTH     (8),
    .DATA_WIDTH     (32),
    .MASK_WIDTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sram_wmask[b]) mem[bus.sram_addr][b*8 +: 8] <= bus.sram_din[b*8 +: 8];
      end
    end
    if (bus.sram_re) bus.sram_dout <= mem[bus.sram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_in();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    bus.sram_dout   = 32'h0;
    bus.bist_start  = 1'b0;
    bus.bist_abort  = 1'b0;
    bus.pattern_sel = 2'd0;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_addr    = 8'h0;
    bus.req_data    = 32'h0;
    bus.req_wmask   = 4'h0;
    bus.eng_addr    = 8'h0;
    bus.eng_data    = 32'h0;
    bus.eng_wmask   = 4'h0;
    bus.eng_we      = 1'b0;
    bus.eng_re      = 1'b0;
    bus.eng_done    = 1'b0;
    bus.eng_fail    = 1'b0;

    // Reset state.
    edge_in(); edge_in(); #1;
    chk("rst_eng_rst", bus.eng_rst, 1);
    chk("rst_eng_en", bus.eng_en, 0);
    edge_in(); rst = 1'b0; #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.bist_busy, 0);
    chk("rst_done", bus.bist_done, 0);
    chk("rst_fail", bus.bist_fail, 0);
    chk("rst_timeout", bus.bist_timeout, 0);
    chk("rst_pat", bus.eng_pattern_sel, 0);
    chk("rst_eng_rst_low", bus.eng_rst, 0);
    chk("rst_sram_we", bus.sram_we, 0);
    chk("rst_sram_re", bus.sram_re, 0);

    // Functional write then read of 0x05.
    edge_in();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h05;
    bus.req_data = 32'hDEADBEEF; bus.req_wmask = 4'hF; #1;
    chk("wr_sram_we", bus.sram_we, 1);
    chk("wr_sram_addr", bus.sram_addr, 8'h05);
    chk("wr_sram_din", bus.sram_din, 32'hDEADBEEF);
    edge_in(); bus.req_we = 1'b0; #1;
    chk("rd_sram_re", bus.sram_re, 1);
    chk("rd_sram_we", bus.sram_we, 0);
    chk("rd_rsp_early", bus.rsp_valid, 0);
    edge_in(); bus.req_valid = 1'b0; #1;
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_data", bus.rsp_data, 32'hDEADBEEF);
    edge_in(); #1;
    chk("rd_rsp_once", bus.rsp_valid, 0);

    // Passing run with pattern 1; engine drives a write that must be blocked in reset.
    edge_in(); bus.bist_start = 1'b1; bus.pattern_sel = 2'd1; bus.req_valid = 1'b1; #1;
    chk("st_req_ready", bus.req_ready, 0);
    chk("st_no_read", bus.sram_re, 0);
    edge_in();
    bus.bist_start = 1'b0; bus.pattern_sel = 2'd0; bus.req_valid = 1'b0;
    bus.eng_we = 1'b1; bus.eng_addr = 8'h33; #1;
    chk("br_eng_rst", bus.eng_rst, 1);
    chk("br_eng_en", bus.eng_en, 0);
    chk("br_busy", bus.bist_busy, 1);
    chk("br_pat", bus.eng_pattern_sel, 1);
    chk("br_sram_we", bus.sram_we, 0);
    chk("br_req_ready", bus.req_ready, 0);
    edge_in(); bus.req_valid = 1'b1; bus.req_we = 1'b0; #1;
    chk("run_eng_rst", bus.eng_rst, 0);
    chk("run_eng_en", bus.eng_en, 1);
    chk("run_req_ready", bus.req_ready, 0);
    chk("run_sram_we", bus.sram_we, 1);
    chk("run_sram_addr", bus.sram_addr, 8'h33);
    chk("run_sram_re", bus.sram_re, 0);
    edge_in(); bus.req_valid = 1'b0; bus.eng_we = 1'b0; bus.eng_done = 1'b1; #1;
    chk("run_done_pending", bus.bist_done, 0);
    edge_in(); bus.eng_done = 1'b0; #1;
    chk("pass_done", bus.bist_done, 1);
    chk("pass_fail", bus.bist_fail, 0);
    chk("pass_busy", bus.bist_busy, 0);
    chk("pass_req_ready", bus.req_ready, 1);
    chk("pass_eng_en", bus.eng_en, 0);

    // Failing run; fail stays sticky through functional traffic.
    edge_in(); bus.bist_start = 1'b1; bus.pattern_sel = 2'd2;
    edge_in(); bus.bist_start = 1'b0; #1;
    chk("f_done_cleared", bus.bist_done, 0);
    chk("f_pat", bus.eng_pattern_sel, 2);
    edge_in(); bus.eng_done = 1'b1; bus.eng_fail = 1'b1;
    edge_in(); bus.eng_done = 1'b0; bus.eng_fail = 1'b0; #1;
    chk("f_done", bus.bist_done, 1);
    chk("f_fail", bus.bist_fail, 1);
    edge_in();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h07;
    bus.req_data = 32'h12345678; bus.req_wmask = 4'b0011;
    edge_in(); bus.req_we = 1'b0;
    edge_in(); bus.req_valid = 1'b0; #1;
    chk("mask_rsp_valid", bus.rsp_valid, 1);
    chk("mask_rsp_data", bus.rsp_data, 32'h00005678);
    chk("f_fail_sticky", bus.bist_fail, 1);

    // Read accepted the cycle before bist_start; engine reads give no response.
    edge_in(); bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h05; #1;
    chk("pre_sram_re", bus.sram_re, 1);
    edge_in(); bus.req_valid = 1'b0; bus.bist_start = 1'b1; bus.pattern_sel = 2'd3; #1;
    chk("pre_rsp_valid", bus.rsp_valid, 1);
    chk("pre_rsp_data", bus.rsp_data, 32'hDEADBEEF);
    edge_in(); bus.bist_start = 1'b0; bus.eng_re = 1'b1; bus.eng_addr = 8'h05; #1;
    chk("pre_rsp_gone", bus.rsp_valid, 0);
    chk("pre_pat", bus.eng_pattern_sel, 3);
    edge_in(); #1;
    chk("eng_rd_sram_re", bus.sram_re, 1);
    chk("eng_rd_rsp0", bus.rsp_valid, 0);
    edge_in(); #1;
    chk("eng_rd_rsp1", bus.rsp_valid, 0);

    // Abort and done together: done wins.
    edge_in(); bus.eng_re = 1'b0; bus.bist_abort = 1'b1; bus.eng_done = 1'b1;
    edge_in(); bus.bist_abort = 1'b0; bus.eng_done = 1'b0; #1;
    chk("ad_done", bus.bist_done, 1);
    chk("ad_fail", bus.bist_fail, 0);
    chk("ad_busy", bus.bist_busy, 0);

    // Abort outside a run is ignored, abort in a run fails it.
    edge_in(); bus.bist_abort = 1'b1;
    edge_in(); bus.bist_abort = 1'b0; #1;
    chk("idle_abort_fail", bus.bist_fail, 0);
    edge_in(); bus.bist_start = 1'b1;
    edge_in(); bus.bist_start = 1'b0; bus.bist_abort = 1'b1;
    edge_in(); #1;
    chk("rst_abort_ignored", bus.eng_en, 1);
    edge_in(); bus.bist_abort = 1'b0; #1;
    chk("ab_done", bus.bist_done, 1);
    chk("ab_fail", bus.bist_fail, 1);
    chk("ab_timeout", bus.bist_timeout, 0);
    chk("ab_busy", bus.bist_busy, 0);

    // Watchdog: 16 run cycles without done; a restart attempt mid-run is ignored.
    edge_in(); bus.bist_start = 1'b1;
    edge_in(); bus.bist_start = 1'b0; #1;
    chk("to_fail_cleared", bus.bist_fail, 0);
    for (int i = 0; i < 16; i++) begin
      edge_in();
      bus.bist_start = (i == 4);
      #1;
      chk($sformatf("to_run_%0d", i), bus.eng_en, 1);
    end
    edge_in(); bus.bist_start = 1'b0; #1;
    chk("to_done", bus.bist_done, 1);
    chk("to_fail", bus.bist_fail, 1);
    chk("to_timeout", bus.bist_timeout, 1);
    chk("to_busy", bus.bist_busy, 0);
    chk("to_req_ready", bus.req_ready, 1);

    // Reset in the middle of a run.
    edge_in(); bus.bist_start = 1'b1; bus.pattern_sel = 2'd2;
    edge_in(); bus.bist_start = 1'b0;
    edge_in(); bus.eng_we = 1'b1; #1;
    chk("mr_sram_we_run", bus.sram_we, 1);
    edge_in(); rst = 1'b1; #1;
    chk("mr_eng_rst", bus.eng_rst, 1);
    chk("mr_eng_en", bus.eng_en, 0);
    chk("mr_sram_we", bus.sram_we, 0);
    edge_in(); rst = 1'b0; bus.eng_we = 1'b0; #1;
    chk("mr_busy", bus.bist_busy, 0);
    chk("mr_done", bus.bist_done, 0);
    chk("mr_fail", bus.bist_fail, 0);
    chk("mr_timeout", bus.bist_timeout, 0);
    chk("mr_pat", bus.eng_pattern_sel, 0);
    chk("mr_req_ready", bus.req_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
